// File: rtl/mem_stage_lsu_if.sv
// Bundle of EX-side, data-memory and WB-side signals around the MEM/LSU stage.
// The stage itself connects through the slave modport; its environment connects through master.
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned RADDR_W = 5
);
  localparam int unsigned STRB_W = XLEN / 8;

  // EX -> MEM op
  logic               ex_valid;
  logic               ex_ready;
  logic               ex_ld;
  logic               ex_st;
  logic [1:0]         ex_size;
  logic               ex_unsigned;
  logic [ADDR_W-1:0]  ex_addr;
  logic [XLEN-1:0]    ex_data;
  logic               ex_w_ena;
  logic [RADDR_W-1:0] ex_w_addr;

  // data-memory request / response
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [XLEN-1:0]    mem_req_wdata;
  logic [STRB_W-1:0]  mem_req_wstrb;
  logic               mem_rsp_valid;
  logic [XLEN-1:0]    mem_rsp_rdata;

  // MEM -> WB result
  logic               wb_valid;
  logic               wb_ready;
  logic [XLEN-1:0]    m_data;
  logic               m_w_ena;
  logic [RADDR_W-1:0] m_w_addr;
  logic               m_misalign;

  modport slave (
    input  ex_valid, ex_ld, ex_st, ex_size, ex_unsigned, ex_addr, ex_data,
           ex_w_ena, ex_w_addr,
    output ex_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output wb_valid, m_data, m_w_ena, m_w_addr, m_misalign,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_ld, ex_st, ex_size, ex_unsigned, ex_addr, ex_data,
           ex_w_ena, ex_w_addr,
    input  ex_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  wb_valid, m_data, m_w_ena, m_w_addr, m_misalign,
    output wb_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load/store unit: pass-through of ALU results, valid/ready
// data-memory port with sized, sign/zero-extended loads and strobed stores.
module mem_stage_lsu #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned RADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic               r_wb_valid;
  logic [XLEN-1:0]    r_m_data;
  logic               r_m_w_ena;
  logic [RADDR_W-1:0] r_m_w_addr;
  logic               r_m_misalign;

  logic               r_req_valid;
  logic               r_req_we;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [XLEN-1:0]    r_req_wdata;
  logic [STRB_W-1:0]  r_req_wstrb;

  logic [1:0]         r_ld_size;
  logic               r_ld_unsigned;
  logic [LANE_W-1:0]  r_ld_lane;
  logic               r_ld_w_ena;
  logic [RADDR_W-1:0] r_ld_w_addr;

  logic               w_wb_valid_nxt;
  logic [XLEN-1:0]    w_m_data_nxt;
  logic               w_m_w_ena_nxt;
  logic [RADDR_W-1:0] w_m_w_addr_nxt;
  logic               w_m_misalign_nxt;
  logic               w_req_valid_nxt;
  logic               w_req_we_nxt;
  logic [ADDR_W-1:0]  w_req_addr_nxt;
  logic [XLEN-1:0]    w_req_wdata_nxt;
  logic [STRB_W-1:0]  w_req_wstrb_nxt;
  logic [1:0]         w_ld_size_nxt;
  logic               w_ld_unsigned_nxt;
  logic [LANE_W-1:0]  w_ld_lane_nxt;
  logic               w_ld_w_ena_nxt;
  logic [RADDR_W-1:0] w_ld_w_addr_nxt;

  logic               w_ex_ready;
  logic               w_accept;
  logic               w_is_mem;
  logic               w_misalign;
  logic [LANE_W-1:0]  w_lane;
  logic [ADDR_W-1:0]  w_aligned_addr;
  logic [XLEN-1:0]    w_wdata;
  logic [7:0]         w_size_mask;
  logic [STRB_W-1:0]  w_wstrb;
  logic [XLEN-1:0]    w_rsp_shift;
  logic [63:0]        w_rsp_64;
  logic [63:0]        w_ext_64;
  logic [XLEN-1:0]    w_ld_data;

  // EX handshake: only idle with a free (or draining) WB slot
  assign w_ex_ready = (r_state == S_IDLE) && (!r_wb_valid || bus.wb_ready);
  assign w_accept   = bus.ex_valid && w_ex_ready;
  assign w_is_mem   = bus.ex_ld || bus.ex_st;
  assign w_lane     = bus.ex_addr[LANE_W-1:0];
  assign w_aligned_addr = {bus.ex_addr[ADDR_W-1:LANE_W], LANE_W'(0)};

  // Natural alignment; doubleword accesses do not exist on a 32-bit datapath
  always_comb begin
    w_misalign = 1'b0;
    unique case (bus.ex_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = bus.ex_addr[0];
      2'd2:    w_misalign = |bus.ex_addr[1:0];
      default: w_misalign = (|bus.ex_addr[2:0]) || (XLEN == 32);
    endcase
  end

  // Store data replicated to every lane and the matching byte-strobe mask
  always_comb begin
    w_wdata     = bus.ex_data;
    w_size_mask = 8'hFF;
    unique case (bus.ex_size)
      2'd0: begin
        w_wdata     = {STRB_W{bus.ex_data[7:0]}};
        w_size_mask = 8'h01;
      end
      2'd1: begin
        w_wdata     = {(STRB_W / 2){bus.ex_data[15:0]}};
        w_size_mask = 8'h03;
      end
      2'd2: begin
        w_wdata     = {(STRB_W / 4){bus.ex_data[31:0]}};
        w_size_mask = 8'h0F;
      end
      default: begin
        w_wdata     = bus.ex_data;
        w_size_mask = 8'hFF;
      end
    endcase
  end

  assign w_wstrb = STRB_W'(w_size_mask) << w_lane;

  // Load lane extraction and extension from the aligned response word
  assign w_rsp_shift = bus.mem_rsp_rdata >> {r_ld_lane, 3'b000};
  assign w_rsp_64    = 64'(w_rsp_shift);

  always_comb begin
    w_ext_64 = w_rsp_64;
    unique case (r_ld_size)
      2'd0: w_ext_64 = r_ld_unsigned ? {56'd0, w_rsp_64[7:0]}
                                     : {{56{w_rsp_64[7]}}, w_rsp_64[7:0]};
      2'd1: w_ext_64 = r_ld_unsigned ? {48'd0, w_rsp_64[15:0]}
                                     : {{48{w_rsp_64[15]}}, w_rsp_64[15:0]};
      2'd2: w_ext_64 = r_ld_unsigned ? {32'd0, w_rsp_64[31:0]}
                                     : {{32{w_rsp_64[31]}}, w_rsp_64[31:0]};
      default: w_ext_64 = w_rsp_64;
    endcase
  end

  assign w_ld_data = XLEN'(w_ext_64);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_is_mem && !w_misalign) w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_req_ready) w_state_nxt = r_req_we ? S_IDLE : S_RSP;
      S_RSP:   if (bus.mem_rsp_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless the state acts on it
  always_comb begin
    w_wb_valid_nxt    = r_wb_valid && !bus.wb_ready;
    w_m_data_nxt      = r_m_data;
    w_m_w_ena_nxt     = r_m_w_ena;
    w_m_w_addr_nxt    = r_m_w_addr;
    w_m_misalign_nxt  = r_m_misalign;
    w_req_valid_nxt   = r_req_valid;
    w_req_we_nxt      = r_req_we;
    w_req_addr_nxt    = r_req_addr;
    w_req_wdata_nxt   = r_req_wdata;
    w_req_wstrb_nxt   = r_req_wstrb;
    w_ld_size_nxt     = r_ld_size;
    w_ld_unsigned_nxt = r_ld_unsigned;
    w_ld_lane_nxt     = r_ld_lane;
    w_ld_w_ena_nxt    = r_ld_w_ena;
    w_ld_w_addr_nxt   = r_ld_w_addr;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            w_wb_valid_nxt   = 1'b1;
            w_m_data_nxt     = bus.ex_data;
            w_m_w_ena_nxt    = bus.ex_w_ena;
            w_m_w_addr_nxt   = bus.ex_w_addr;
            w_m_misalign_nxt = 1'b0;
          end else if (w_misalign) begin
            w_wb_valid_nxt   = 1'b1;
            w_m_data_nxt     = '0;
            w_m_w_ena_nxt    = 1'b0;
            w_m_w_addr_nxt   = bus.ex_w_addr;
            w_m_misalign_nxt = 1'b1;
          end else begin
            w_req_valid_nxt   = 1'b1;
            w_req_we_nxt      = bus.ex_st;
            w_req_addr_nxt    = w_aligned_addr;
            w_req_wdata_nxt   = w_wdata;
            w_req_wstrb_nxt   = w_wstrb;
            w_ld_size_nxt     = bus.ex_size;
            w_ld_unsigned_nxt = bus.ex_unsigned;
            w_ld_lane_nxt     = w_lane;
            w_ld_w_ena_nxt    = bus.ex_w_ena;
            w_ld_w_addr_nxt   = bus.ex_w_addr;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          w_req_valid_nxt = 1'b0;
          // a store retires on the request handshake; no response is awaited
          if (r_req_we) begin
            w_wb_valid_nxt   = 1'b1;
            w_m_data_nxt     = '0;
            w_m_w_ena_nxt    = 1'b0;
            w_m_w_addr_nxt   = r_ld_w_addr;
            w_m_misalign_nxt = 1'b0;
          end
        end
      end
      S_RSP: begin
        if (bus.mem_rsp_valid) begin
          w_wb_valid_nxt   = 1'b1;
          w_m_data_nxt     = w_ld_data;
          w_m_w_ena_nxt    = r_ld_w_ena;
          w_m_w_addr_nxt   = r_ld_w_addr;
          w_m_misalign_nxt = 1'b0;
        end
      end
      default: begin
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and in-flight op context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid    <= 1'b0;
      r_m_data      <= '0;
      r_m_w_ena     <= 1'b0;
      r_m_w_addr    <= '0;
      r_m_misalign  <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_we      <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_req_wstrb   <= '0;
      r_ld_size     <= 2'd0;
      r_ld_unsigned <= 1'b0;
      r_ld_lane     <= '0;
      r_ld_w_ena    <= 1'b0;
      r_ld_w_addr   <= '0;
    end else begin
      r_wb_valid    <= w_wb_valid_nxt;
      r_m_data      <= w_m_data_nxt;
      r_m_w_ena     <= w_m_w_ena_nxt;
      r_m_w_addr    <= w_m_w_addr_nxt;
      r_m_misalign  <= w_m_misalign_nxt;
      r_req_valid   <= w_req_valid_nxt;
      r_req_we      <= w_req_we_nxt;
      r_req_addr    <= w_req_addr_nxt;
      r_req_wdata   <= w_req_wdata_nxt;
      r_req_wstrb   <= w_req_wstrb_nxt;
      r_ld_size     <= w_ld_size_nxt;
      r_ld_unsigned <= w_ld_unsigned_nxt;
      r_ld_lane     <= w_ld_lane_nxt;
      r_ld_w_ena    <= w_ld_w_ena_nxt;
      r_ld_w_addr   <= w_ld_w_addr_nxt;
    end
  end

  assign bus.ex_ready      = w_ex_ready;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_we    = r_req_we;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.mem_req_wstrb = r_req_wstrb;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.m_data        = r_m_data;
  assign bus.m_w_ena       = r_m_w_ena;
  assign bus.m_w_addr      = r_m_w_addr;
  assign bus.m_misalign    = r_m_misalign;

endmodule
